// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter among N_REQ byte streams: packet-granular round-robin
// arbitration plus sequencing of the UART load (byte_ready) / start (tx_byte) / tx_busy handshake.
module uart_tx_scheduler #(
    parameter int N_REQ         = 3,
    parameter int LOAD_CYCLES   = 2,
    parameter int START_TIMEOUT = 16
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [8*N_REQ-1:0]         req_data,
    input  logic [N_REQ-1:0]           req_last,
    output logic [N_REQ-1:0]           req_ready,
    output logic [7:0]                 uart_data,
    output logic                       uart_byte_ready,
    output logic                       uart_tx_byte,
    input  logic                       uart_tx_busy,
    output logic [$clog2(N_REQ)-1:0]   grant_id,
    output logic                       locked,
    output logic                       err_timeout,
    output logic                       sched_busy
);

    // state       | meaning
    // S_IDLE      | arbitrate; grant when UART idle and an eligible requester is valid
    // S_LOAD      | byte_ready high, uart_data stable, LOAD_CYCLES cycles
    // S_START     | one-cycle tx_byte start pulse
    // S_WAIT_BUSY | wait for tx_busy to rise, bounded by START_TIMEOUT
    // S_WAIT_DONE | wait for tx_busy to fall, then update lock / round-robin pointer
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT_BUSY,
        S_WAIT_DONE
    } state_t;

    localparam int IDW     = $clog2(N_REQ);
    localparam int CNT_MAX = (LOAD_CYCLES > START_TIMEOUT) ? LOAD_CYCLES : START_TIMEOUT;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [IDW:0] N_W = (IDW+1)'(N_REQ);

    state_t           r_state;
    state_t           w_next_state;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic             r_locked;
    logic             r_last_q;
    logic [7:0]       r_uart_data;
    logic [CW-1:0]    r_cnt;

    logic             w_found;
    logic [IDW-1:0]   w_sel;
    logic [IDW:0]     w_cand;
    logic [7:0]       w_sel_data;
    logic             w_sel_last;
    logic             w_grant;
    logic             w_timeout;
    logic             w_done;
    logic [IDW-1:0]   w_ptr_next;

    // Descending search so the candidate closest to rr_ptr is the one that sticks.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_cand  = '0;
        if (r_locked) begin
            w_sel   = r_grant_id;
            w_found = req_valid[r_grant_id];
        end else begin
            for (int k = N_REQ - 1; k >= 0; k--) begin
                w_cand = {1'b0, r_rr_ptr} + (IDW+1)'(k);
                if (w_cand >= N_W) begin
                    w_cand = w_cand - N_W;
                end
                if (req_valid[w_cand[IDW-1:0]]) begin
                    w_found = 1'b1;
                    w_sel   = w_cand[IDW-1:0];
                end
            end
        end
    end

    always_comb begin
        w_sel_data = '0;
        w_sel_last = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_sel == IDW'(i)) begin
                w_sel_data = req_data[8*i +: 8];
                w_sel_last = req_last[i];
            end
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_grant      = 1'b0;
        w_timeout    = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!uart_tx_busy && w_found) begin
                    w_grant      = 1'b1;
                    w_next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (r_cnt == '0) begin
                    w_next_state = S_START;
                end
            end
            S_START: begin
                w_next_state = S_WAIT_BUSY;
            end
            S_WAIT_BUSY: begin
                if (uart_tx_busy) begin
                    w_next_state = S_WAIT_DONE;
                end else if (r_cnt == '0) begin
                    w_timeout    = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            S_WAIT_DONE: begin
                if (!uart_tx_busy) begin
                    w_done       = 1'b1;
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    assign w_ptr_next = (r_grant_id == IDW'(N_REQ - 1)) ? '0 : r_grant_id + IDW'(1);

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            r_rr_ptr    <= '0;
            r_grant_id  <= '0;
            r_locked    <= 1'b0;
            r_last_q    <= 1'b0;
            r_uart_data <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_uart_data <= w_sel_data;
                        r_last_q    <= w_sel_last;
                        r_grant_id  <= w_sel;
                        r_cnt       <= CW'(LOAD_CYCLES - 1);
                    end
                end
                S_LOAD: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_START: begin
                    r_cnt <= CW'(START_TIMEOUT - 1);
                end
                S_WAIT_BUSY: begin
                    if (r_cnt != '0) begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                default: begin
                end
            endcase

            // A timed-out byte ends its packet: the owner loses the lock.
            if (w_timeout || (w_done && r_last_q)) begin
                r_locked <= 1'b0;
                r_rr_ptr <= w_ptr_next;
            end else if (w_done) begin
                r_locked <= 1'b1;
            end
        end
    end

    assign req_ready       = (w_grant && !reset) ? (N_REQ'(1) << w_sel) : '0;
    assign uart_data       = r_uart_data;
    assign uart_byte_ready = (r_state == S_LOAD);
    assign uart_tx_byte    = (r_state == S_START);
    assign grant_id        = r_grant_id;
    assign locked          = r_locked;
    assign err_timeout     = w_timeout && !reset;
    assign sched_busy      = (r_state != S_IDLE);

endmodule
